// File: rtl/memory_arbiter_if.sv
// Requester-side bundle for memory_arbiter: request payload in,
// accept strobe and read response out.
interface memory_arbiter_if;
    logic        enable;
    logic        command;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] write_mask;
    logic        ready;
    logic        valid;
    logic        error;
    logic [31:0] read_data;

    modport master (
        output enable, command,
        output read_address, write_address,
        output write_data, write_mask,
        input  ready, valid, error, read_data
    );

    modport slave (
        input  enable, command,
        input  read_address, write_address,
        input  write_data, write_mask,
        output ready, valid, error, read_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-requester arbiter onto one memory port, one read outstanding.
// Define MEMORY_ARBITER_FIXED_PRIORITY_EN for fixed r0-first priority.
module memory_arbiter #(
    parameter int READ_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    memory_arbiter_if.slave r0,
    memory_arbiter_if.slave r1,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] read_memory_data,
    output logic        memory_enable,
    output logic        memory_command_out,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask
);

    localparam bit TMO_EN = READ_TIMEOUT > 0;
    localparam int CW =
        TMO_EN ? $clog2(READ_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(READ_TIMEOUT);

    typedef enum logic {
        IDLE,
        READ_WAIT
    } state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic any_req;
    logic win;
    logic win_cmd;
    logic accept;
    logic timeout_hit;
    logic done;

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        win = ~r0.enable;
    end
`else
    // last_q names the requester granted most recently
    logic last_q, last_d;

    always_comb begin
        if (r0.enable && r1.enable) begin
            win = ~last_q;
        end else begin
            win = ~r0.enable;
        end
    end
`endif

    always_comb begin
        any_req = r0.enable | r1.enable;
        win_cmd = win ? r1.command : r0.command;
        accept  = (state_q == IDLE) & any_req & memory_ready;
        timeout_hit = TMO_EN && (cnt_q == TMO)
                      && !memory_valid;
        done = (state_q == READ_WAIT)
               & (memory_valid | timeout_hit);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifndef MEMORY_ARBITER_FIXED_PRIORITY_EN
                    last_d = win;
`endif
                    if (!win_cmd) begin
                        state_d = READ_WAIT;
                        owner_d = win;
                        cnt_d   = '0;
                    end
                end
            end
            READ_WAIT: begin
                if (done) begin
                    state_d = IDLE;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_data;

    always_comb begin
        memory_enable        = 1'b0;
        memory_command_out   = 1'b0;
        read_memory_address  = '0;
        write_memory_address = '0;
        write_memory_data    = '0;
        write_memory_mask    = '0;
        r0.ready  = 1'b0;
        r1.ready  = 1'b0;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_data  = '0;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    memory_enable = any_req;
                    if (any_req) begin
                        memory_command_out = win_cmd;
                        read_memory_address =
                            win ? r1.read_address
                                : r0.read_address;
                        write_memory_address =
                            win ? r1.write_address
                                : r0.write_address;
                        write_memory_data =
                            win ? r1.write_data
                                : r0.write_data;
                        write_memory_mask =
                            win ? r1.write_mask
                                : r0.write_mask;
                    end
                    r0.ready = accept & ~win;
                    r1.ready = accept & win;
                end
                READ_WAIT: begin
                    // memory_valid beats a coincident timeout
                    rsp_valid = done;
                    rsp_error = done & ~memory_valid;
                    if (memory_valid) begin
                        rsp_data = read_memory_data;
                    end
                end
            endcase
        end
    end

    always_comb begin
        r0.valid     = rsp_valid & ~owner_q;
        r0.error     = rsp_error & ~owner_q;
        r0.read_data = owner_q ? '0 : rsp_data;
        r1.valid     = rsp_valid & owner_q;
        r1.error     = rsp_error & owner_q;
        r1.read_data = owner_q ? rsp_data : '0;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter against a transaction-level
// reference model (busy flag, owner, wait count, last grant).
module tb_memory_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  en, cmd;
    logic [31:0] ra[2], wa[2], wd[2], wm[2];
    logic        mready, mvalid;
    logic [31:0] rmd;

    logic        men, mcmd;
    logic [31:0] rma, wma, wmd, wmm;

    memory_arbiter_if r0_if ();
    memory_arbiter_if r1_if ();

    assign r0_if.enable        = en[0];
    assign r0_if.command       = cmd[0];
    assign r0_if.read_address  = ra[0];
    assign r0_if.write_address = wa[0];
    assign r0_if.write_data    = wd[0];
    assign r0_if.write_mask    = wm[0];
    assign r1_if.enable        = en[1];
    assign r1_if.command       = cmd[1];
    assign r1_if.read_address  = ra[1];
    assign r1_if.write_address = wa[1];
    assign r1_if.write_data    = wd[1];
    assign r1_if.write_mask    = wm[1];

    memory_arbiter #(.READ_TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .reset                (rst_n),
        .r0                   (r0_if),
        .r1                   (r1_if),
        .memory_ready         (mready),
        .memory_valid         (mvalid),
        .read_memory_data     (rmd),
        .memory_enable        (men),
        .memory_command_out   (mcmd),
        .read_memory_address  (rma),
        .write_memory_address (wma),
        .write_memory_data    (wmd),
        .write_memory_mask    (wmm)
    );

    logic [199:0] obs, exp_v;
    assign obs = {men, mcmd, rma, wma, wmd, wmm,
                  r0_if.ready, r0_if.valid, r0_if.error,
                  r0_if.read_data,
                  r1_if.ready, r1_if.valid, r1_if.error,
                  r1_if.read_data};

    int n_tests = 0;
    int n_fail  = 0;

    bit m_busy;
    int m_owner, m_wait, m_last;

    function automatic int pick();
        if (en == 2'b11) begin
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
            return 0;
`else
            return 1 - m_last;
`endif
        end
        return en[0] ? 0 : 1;
    endfunction

    task automatic model_eval();
        logic        e_men, e_cmd;
        logic [31:0] e_ra, e_wa, e_wd, e_wm;
        logic [1:0]  e_rdy, e_val, e_err;
        logic [31:0] e_rd[2];
        int w;
        e_men = 0; e_cmd = 0;
        e_ra = 0; e_wa = 0; e_wd = 0; e_wm = 0;
        e_rdy = 0; e_val = 0; e_err = 0;
        e_rd[0] = 0; e_rd[1] = 0;
        if (rst_n) begin
            if (!m_busy) begin
                if (en != 2'b00) begin
                    w = pick();
                    e_men = 1;
                    e_cmd = cmd[w];
                    e_ra = ra[w]; e_wa = wa[w];
                    e_wd = wd[w]; e_wm = wm[w];
                    e_rdy[w] = mready;
                end
            end else if (mvalid) begin
                e_val[m_owner] = 1;
                e_rd[m_owner] = rmd;
            end else if (TMO > 0 && m_wait == TMO) begin
                e_val[m_owner] = 1;
                e_err[m_owner] = 1;
            end
        end
        exp_v = {e_men, e_cmd, e_ra, e_wa, e_wd, e_wm,
                 e_rdy[0], e_val[0], e_err[0], e_rd[0],
                 e_rdy[1], e_val[1], e_err[1], e_rd[1]};
    endtask

    task automatic model_commit();
        int w;
        if (!rst_n) begin
            m_busy = 0; m_wait = 0; m_last = 1;
        end else if (!m_busy) begin
            if (en != 2'b00 && mready) begin
                w = pick();
                m_last = w;
                if (!cmd[w]) begin
                    m_busy = 1; m_owner = w; m_wait = 0;
                end
            end
        end else if (mvalid || (TMO > 0 && m_wait == TMO)) begin
            m_busy = 0;
        end else begin
            m_wait++;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; cmd = 0;
        for (int i = 0; i < 2; i++) begin
            ra[i] = 0; wa[i] = 0; wd[i] = 0; wm[i] = 0;
        end
        mready = 1; mvalid = 0; rmd = 0;
    endtask

    task automatic rand_payload();
        for (int i = 0; i < 2; i++) begin
            ra[i] = $urandom; wa[i] = $urandom;
            wd[i] = $urandom; wm[i] = $urandom;
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        advance();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        en = 2'b11; cmd = 2'b00; rand_payload();
        mvalid = 1; rmd = 32'h1234_5678;
        settle();
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_vec got %h want %h", obs, exp_v);
        end
        n_tests++;
        if (obs !== 200'd0) begin
            n_fail++;
            $display("FAIL reset_zero got %h want 0", obs);
        end
        advance();
        apply_reset();
    endtask

    task automatic test_single_read();
        int rdy_cnt;
        apply_reset();
        en[0] = 1; cmd[0] = 0; ra[0] = 32'h100;
        settle();
        rdy_cnt = r0_if.ready;
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL rd_accept got %h want %h", obs, exp_v);
        end
        n_tests++;
        if ({men, r0_if.ready, r1_if.ready, rma} !== {3'b110, 32'h100}) begin
            n_fail++;
            $display("FAIL rd_req got %b%b%b %h want 110 100",
                     men, r0_if.ready, r1_if.ready, rma);
        end
        advance();
        en = 0;
        for (int k = 1; k <= 3; k++) begin
            mvalid = (k == 3);
            rmd = (k == 3) ? 32'hDEAD_BEEF : $urandom;
            settle();
            rdy_cnt += r0_if.ready;
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rd_wait%0d got %h want %h", k, obs, exp_v);
            end
            if (k == 3) begin
                n_tests++;
                if ({r0_if.valid, r0_if.error, r0_if.read_data,
                     r1_if.valid, r1_if.read_data}
                    !== {2'b10, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
                    n_fail++;
                    $display("FAIL rd_resp got %b %h r1 %b %h want 1 deadbeef r1 0 0",
                             r0_if.valid, r0_if.read_data,
                             r1_if.valid, r1_if.read_data);
                end
            end
            advance();
        end
        mvalid = 0;
        n_tests++;
        if (rdy_cnt != 1) begin
            n_fail++;
            $display("FAIL rd_ready_pulses got %0d want 1", rdy_cnt);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int want[4];
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
        want = '{0, 0, 0, 0};
`else
        want = '{0, 1, 0, 1};
`endif
        apply_reset();
        en = 2'b11; cmd = 2'b11; mready = 1;
        for (int c = 0; c < 4; c++) begin
            rand_payload();
            settle();
            if (r0_if.ready) got.push_back(0);
            if (r1_if.ready) got.push_back(1);
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_vec%0d got %h want %h", c, obs, exp_v);
            end
            advance();
        end
        en = 0;
        n_tests++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got[i] != want[i]) begin
                    n_fail++;
                    $display("FAIL rr_order%0d got r%0d want r%0d",
                             i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int acc;
        apply_reset();
        en = 2'b11; cmd = 2'b11; rand_payload();
        mready = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_tests++;
            if ({r0_if.ready, r1_if.ready, men} !== 3'b001
                || wma !== wa[0] || wmd !== wd[0]) begin
                n_fail++;
                $display("FAIL stall%0d got rdy %b%b en %b wa %h want 00 1 %h",
                         c, r0_if.ready, r1_if.ready, men, wma, wa[0]);
            end
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stall_vec%0d got %h want %h", c, obs, exp_v);
            end
            advance();
        end
        mready = 1;
        settle();
        acc = int'(r0_if.ready) + int'(r1_if.ready);
        n_tests++;
        if (acc != 1) begin
            n_fail++;
            $display("FAIL stall_release got %0d accepts want 1", acc);
        end
        advance();
        en = 0;
    endtask

    task automatic test_timeout();
        apply_reset();
        en[1] = 1; cmd[1] = 0; ra[1] = $urandom;
        settle();
        n_tests++;
        if (r1_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_accept got %b want 1", r1_if.ready);
        end
        advance();
        en = 0;
        for (int k = 0; k <= TMO; k++) begin
            settle();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL to_vec%0d got %h want %h", k, obs, exp_v);
            end
            n_tests++;
            if (k < TMO && r1_if.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL to_early%0d got valid %b want 0", k, r1_if.valid);
            end else if (k == TMO
                         && {r1_if.valid, r1_if.error, r1_if.read_data}
                            !== {2'b11, 32'h0}) begin
                n_fail++;
                $display("FAIL to_hit got %b%b %h want 11 0",
                         r1_if.valid, r1_if.error, r1_if.read_data);
            end
            advance();
        end
        en[0] = 1; cmd[0] = 1;
        settle();
        n_tests++;
        if (r0_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_next got r0_ready %b want 1", r0_if.ready);
        end
        advance();
        en = 0;
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        en[0] = 1; cmd[0] = 0; ra[0] = $urandom;
        settle();
        advance();
        en = 0;
        rst_n = 0;
        settle();
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_rst got %h want %h", obs, exp_v);
        end
        advance();
        rst_n = 1;
        mvalid = 1; rmd = $urandom;
        settle();
        n_tests++;
        if ({r0_if.valid, r1_if.valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_late got %b%b want 00", r0_if.valid, r1_if.valid);
        end
        advance();
        mvalid = 0;
        en = 2'b11; cmd = 2'b11;
        settle();
        n_tests++;
        if ({r0_if.ready, r1_if.ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_tie got %b%b want 10", r0_if.ready, r1_if.ready);
        end
        advance();
        en = 0;
    endtask

    task automatic test_stray();
        apply_reset();
        mvalid = 1; rmd = $urandom;
        settle();
        n_tests++;
        if ({r0_if.valid, r1_if.valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL stray got %b%b want 00", r0_if.valid, r1_if.valid);
        end
        advance();
        mvalid = 0;
        en[1] = 1; cmd[1] = 0;
        settle();
        advance();
        en = 0;
        for (int k = 0; k <= TMO; k++) begin
            mvalid = (k == TMO);
            rmd = 32'hCAFE_0000 + k;
            settle();
            if (k == TMO) begin
                n_tests++;
                if ({r1_if.valid, r1_if.error, r1_if.read_data}
                    !== {2'b10, 32'hCAFE_0000 + TMO}) begin
                    n_fail++;
                    $display("FAIL simul got %b%b %h want 10 %h",
                             r1_if.valid, r1_if.error, r1_if.read_data,
                             32'hCAFE_0000 + TMO);
                end
            end
            advance();
        end
        mvalid = 0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            en = 2'($urandom);
            cmd = 2'($urandom);
            rand_payload();
            mready = ($urandom_range(0, 3) != 0);
            mvalid = ($urandom_range(0, 4) == 0);
            rmd = $urandom;
            rst_n = ($urandom_range(0, 49) != 0);
            settle();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rand%0d got %h want %h", c, obs, exp_v);
            end
            advance();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        m_busy = 0; m_owner = 0; m_wait = 0; m_last = 1;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall();
        test_timeout();
        test_reset_mid_read();
        test_stray();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
